// File: rtl/loop_addr_gen_pkg.sv
// Shared types and default widths for the loop_addr_gen sequencer.
package loop_addr_gen_pkg;

  localparam int CW_DEF = 4;
  localparam int AW_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/loop_addr_gen_if.sv
// Run-control, configuration and address stream bundle between a controller and loop_addr_gen.
interface loop_addr_gen_if
  import loop_addr_gen_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
);
  logic          start;
  logic [CW-1:0] c_fin;
  logic [CW-1:0] y_fin;
  logic [CW-1:0] x_fin;
  logic [AW-1:0] w_base;
  logic [AW-1:0] i_base;
  logic [AW-1:0] w_sc;
  logic [AW-1:0] w_sy;
  logic [AW-1:0] i_sc;
  logic [AW-1:0] i_sy;
  logic          ready;
  logic          valid;
  logic [AW-1:0] wa;
  logic [AW-1:0] ia;
  logic          last;
  logic          busy;
  logic          done;

  modport master (
    output start, c_fin, y_fin, x_fin, w_base, i_base, w_sc, w_sy, i_sc, i_sy, ready,
    input  valid, wa, ia, last, busy, done
  );

  modport slave (
    input  start, c_fin, y_fin, x_fin, w_base, i_base, w_sc, w_sy, i_sc, i_sy, ready,
    output valid, wa, ia, last, busy, done
  );

endinterface

// File: rtl/loop_addr_gen_loop_lvl.sv
// One loop level: index counts 0..fin on each enabled step and wraps to 0, flagging the carry.
module loop_lvl
  import loop_addr_gen_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] fin,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] index,
  output logic          at_fin,
  output logic          wrap
);

  assign at_fin = (index == fin);
  assign wrap   = en && at_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (en) begin
      index <= at_fin ? '0 : index + CW'(1);
    end
  end

endmodule

// File: rtl/loop_addr_gen.sv
// Three-level (c/y/x) loop sequencer producing weight/input addresses on a valid/ready stream.
// Build option LOOP_ADDR_GEN_REG_OUT_EN adds a registered output stage (latency 2, full throughput).
module loop_addr_gen
  import loop_addr_gen_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
) (
  input logic            clk,
  input logic            rst,
  loop_addr_gen_if.slave bus
);

  state_t        state;
  logic [CW-1:0] c_fin_r, y_fin_r, x_fin_r;
  logic [AW-1:0] w_sc_r, w_sy_r, i_sc_r, i_sy_r;
  logic          vld_p0;
  logic          done_r;
  logic [AW-1:0] wa_p0, ia_p0;
  logic [AW-1:0] w_yrow_p0, w_crow_p0, i_yrow_p0, i_crow_p0;
  logic [AW-1:0] w_ynext, w_cnext, i_ynext, i_cnext;
  logic [CW-1:0] c_idx, y_idx, x_idx;
  logic          c_at, y_at, x_at;
  logic          c_wrap, y_wrap, x_wrap;
  logic          launch, last_p0, step_p0, out_last_xfer;
  logic          unused_idx;

  assign launch  = (state == IDLE) && bus.start;
  assign last_p0 = vld_p0 && c_at && y_at && x_at;

  // Indices are kept for debug visibility; only the fin/wrap flags steer the addresses.
  assign unused_idx = ^{c_idx, y_idx, x_idx};

  loop_lvl #(.CW(CW)) u_lvl_x (
    .clk(clk), .rst(rst), .fin(x_fin_r), .clear(launch), .en(step_p0),
    .index(x_idx), .at_fin(x_at), .wrap(x_wrap)
  );

  loop_lvl #(.CW(CW)) u_lvl_y (
    .clk(clk), .rst(rst), .fin(y_fin_r), .clear(launch), .en(x_wrap),
    .index(y_idx), .at_fin(y_at), .wrap(y_wrap)
  );

  loop_lvl #(.CW(CW)) u_lvl_c (
    .clk(clk), .rst(rst), .fin(c_fin_r), .clear(launch), .en(y_wrap),
    .index(c_idx), .at_fin(c_at), .wrap(c_wrap)
  );

  assign w_ynext = w_yrow_p0 + w_sy_r;
  assign i_ynext = i_yrow_p0 + i_sy_r;
  assign w_cnext = w_crow_p0 + w_sc_r;
  assign i_cnext = i_crow_p0 + i_sc_r;

  // p0: run control and latched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vld_p0  <= 1'b0;
      done_r  <= 1'b0;
      c_fin_r <= '0;
      y_fin_r <= '0;
      x_fin_r <= '0;
      w_sc_r  <= '0;
      w_sy_r  <= '0;
      i_sc_r  <= '0;
      i_sy_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            c_fin_r <= bus.c_fin;
            y_fin_r <= bus.y_fin;
            x_fin_r <= bus.x_fin;
            w_sc_r  <= bus.w_sc;
            w_sy_r  <= bus.w_sy;
            i_sc_r  <= bus.i_sc;
            i_sy_r  <= bus.i_sy;
            vld_p0  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (step_p0 && last_p0) begin
            vld_p0 <= 1'b0;
          end
          if (out_last_xfer) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: incremental address accumulators; the final step wraps all levels and leaves addresses alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_p0     <= '0;
      ia_p0     <= '0;
      w_yrow_p0 <= '0;
      w_crow_p0 <= '0;
      i_yrow_p0 <= '0;
      i_crow_p0 <= '0;
    end else if (launch) begin
      wa_p0     <= bus.w_base;
      ia_p0     <= bus.i_base;
      w_yrow_p0 <= bus.w_base;
      w_crow_p0 <= bus.w_base;
      i_yrow_p0 <= bus.i_base;
      i_crow_p0 <= bus.i_base;
    end else if (step_p0) begin
      if (!x_wrap) begin
        wa_p0 <= wa_p0 + AW'(1);
        ia_p0 <= ia_p0 + AW'(1);
      end else if (!y_wrap) begin
        wa_p0     <= w_ynext;
        ia_p0     <= i_ynext;
        w_yrow_p0 <= w_ynext;
        i_yrow_p0 <= i_ynext;
      end else if (!c_wrap) begin
        wa_p0     <= w_cnext;
        ia_p0     <= i_cnext;
        w_yrow_p0 <= w_cnext;
        i_yrow_p0 <= i_cnext;
        w_crow_p0 <= w_cnext;
        i_crow_p0 <= i_cnext;
      end
    end
  end

`ifdef LOOP_ADDR_GEN_REG_OUT_EN
  logic          vld_p1;
  logic          last_p1;
  logic [AW-1:0] wa_p1, ia_p1;

  assign step_p0       = vld_p0 && (!vld_p1 || bus.ready);
  assign out_last_xfer = vld_p1 && last_p1 && bus.ready;

  // p1: output register, refilled whenever it is empty or being drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      wa_p1   <= '0;
      ia_p1   <= '0;
    end else if (!vld_p1 || bus.ready) begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      wa_p1   <= wa_p0;
      ia_p1   <= ia_p0;
    end
  end

  assign bus.valid = vld_p1;
  assign bus.last  = last_p1;
  assign bus.wa    = wa_p1;
  assign bus.ia    = ia_p1;
`else
  assign step_p0       = vld_p0 && bus.ready;
  assign out_last_xfer = step_p0 && last_p0;

  assign bus.valid = vld_p0;
  assign bus.last  = last_p0;
  assign bus.wa    = wa_p0;
  assign bus.ia    = ia_p0;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;

endmodule

// File: tb/tb_loop_addr_gen.sv
// Self-checking bench for loop_addr_gen: nested-loop reference model, random ready and random configs.
module tb_loop_addr_gen;
  import loop_addr_gen_pkg::*;

  localparam int CW = CW_DEF;
  localparam int AW = AW_DEF;
`ifdef LOOP_ADDR_GEN_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loop_addr_gen_if #(.CW(CW), .AW(AW)) bus ();
  loop_addr_gen #(.CW(CW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] cfg_c_fin, cfg_y_fin, cfg_x_fin;
  logic [AW-1:0] cfg_w_base, cfg_i_base, cfg_w_sc, cfg_w_sy, cfg_i_sc, cfg_i_sy;

  logic [AW-1:0] exp_wa[$], exp_ia[$];
  bit            exp_last[$];
  logic [AW-1:0] obs_wa[$], obs_ia[$];
  bit            obs_last[$];
  logic [AW-1:0] stall_wa[$], stall_ia[$];
  bit            stall_vld[$];
  int lat_obs, last_cyc, done_cyc, done_cnt, busy_low, timed_out;
  logic busy_at_done, valid_at_done;

  task automatic drive_cfg();
    bus.c_fin  = cfg_c_fin;  bus.y_fin  = cfg_y_fin;  bus.x_fin = cfg_x_fin;
    bus.w_base = cfg_w_base; bus.i_base = cfg_i_base;
    bus.w_sc   = cfg_w_sc;   bus.w_sy   = cfg_w_sy;
    bus.i_sc   = cfg_i_sc;   bus.i_sy   = cfg_i_sy;
  endtask

  task automatic set_basic();
    cfg_c_fin = 1; cfg_y_fin = 2; cfg_x_fin = 2;
    cfg_w_base = 0; cfg_i_base = 0;
    cfg_w_sc = 9; cfg_w_sy = 3; cfg_i_sc = 100; cfg_i_sy = 10;
  endtask

  // Reference: every (c,y,x) in loop order, address = base + c*sc + y*sy + x modulo 2^AW.
  task automatic build_model();
    exp_wa.delete(); exp_ia.delete(); exp_last.delete();
    for (int c = 0; c <= int'(cfg_c_fin); c++)
      for (int y = 0; y <= int'(cfg_y_fin); y++)
        for (int x = 0; x <= int'(cfg_x_fin); x++) begin
          exp_wa.push_back(cfg_w_base + AW'(c) * cfg_w_sc + AW'(y) * cfg_w_sy + AW'(x));
          exp_ia.push_back(cfg_i_base + AW'(c) * cfg_i_sc + AW'(y) * cfg_i_sy + AW'(x));
          exp_last.push_back(c == int'(cfg_c_fin) && y == int'(cfg_y_fin) && x == int'(cfg_x_fin));
        end
  endtask

  task automatic kick();
    @(negedge clk);
    drive_cfg();
    bus.ready = 1'b1;
    bus.start = 1'b1;
  endtask

  // Observes one run from the cycle after start; mode 0 ready=1, 1 stall window, 2 random ready.
  task automatic collect(input int mode, input int stall_at, input int stall_len,
                         input int mid_at, input bit restart);
    int beats, stalls_left;
    bit r, mid_done;
    obs_wa.delete(); obs_ia.delete(); obs_last.delete();
    stall_wa.delete(); stall_ia.delete(); stall_vld.delete();
    lat_obs = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; busy_low = 0; timed_out = 1;
    beats = 0; stalls_left = stall_len; mid_done = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_cfg();
      if (bus.valid && lat_obs < 0) lat_obs = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = bus.busy; valid_at_done = bus.valid;
        end
      end
      if (lat_obs > 0 && done_cyc < 0 && bus.busy !== 1'b1) busy_low++;
      if (done_cyc >= 0 && restart) begin
        bus.start = 1'b1; timed_out = 0; break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
        timed_out = 0; break;
      end
      r = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && lat_obs > 0 && beats == stall_at && stalls_left > 0) begin
        r = 1'b0; stalls_left--;
        stall_wa.push_back(bus.wa); stall_ia.push_back(bus.ia); stall_vld.push_back(bus.valid);
      end
      if (mid_at >= 0 && !mid_done && beats == mid_at && bus.valid) begin
        bus.start = 1'b1; bus.c_fin = 0; bus.y_fin = 0; bus.x_fin = 0;
        bus.w_base = 32'h5555_0000; bus.i_base = 32'h6666_0000; mid_done = 1;
      end
      bus.ready = r;
      if (bus.valid && r) begin
        obs_wa.push_back(bus.wa); obs_ia.push_back(bus.ia); obs_last.push_back(bus.last);
        beats++;
        if (bus.last) last_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.ready = 0;
    set_basic(); drive_cfg();
    repeat (3) @(negedge clk);
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", bus.last); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.wa !== '0 || bus.ia !== '0) begin miscompares++; $display("FAIL reset_addr got wa=%h ia=%h want 0", bus.wa, bus.ia); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_basic(); build_model(); kick();
    collect(0, -1, 0, -1, 1'b0);
    vectors++; if (timed_out != 0) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
    vectors++; if (obs_wa.size() != 18) begin miscompares++; $display("FAIL basic_count got %0d want 18", obs_wa.size()); end
    for (int i = 0; i < exp_wa.size(); i++) begin
      vectors++;
      if (obs_wa[i] !== exp_wa[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL basic_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                 i, obs_wa[i], obs_ia[i], obs_last[i], exp_wa[i], exp_ia[i], exp_last[i]);
      end
    end
    vectors++; if (obs_ia[3] !== 32'd10 || obs_wa[17] !== 32'd17 || obs_ia[17] !== 32'd122) begin
      miscompares++; $display("FAIL basic_spot got ia3=%0d wa17=%0d ia17=%0d want 10 17 122", obs_ia[3], obs_wa[17], obs_ia[17]);
    end
    vectors++; if (lat_obs != LAT) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat_obs, LAT); end
    vectors++; if (last_cyc + 17 != lat_obs + 17 + 17 - 17 + 0 && last_cyc != lat_obs + 17) begin
      miscompares++; $display("FAIL basic_throughput got last at %0d want %0d", last_cyc, lat_obs + 17);
    end
    vectors++; if (done_cyc != last_cyc + 1 || done_cnt != 1) begin
      miscompares++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=%0d cnt=1", done_cyc, done_cnt, last_cyc + 1);
    end
    vectors++; if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle_at_done got busy=%b valid=%b want 0 0", busy_at_done, valid_at_done);
    end
    vectors++; if (busy_low != 0) begin miscompares++; $display("FAIL basic_busy got %0d low cycles want 0", busy_low); end
  endtask

  task automatic test_backpressure();
    set_basic(); build_model(); kick();
    collect(1, 4, 3, -1, 1'b0);
    vectors++; if (timed_out != 0 || obs_wa.size() != 18) begin
      miscompares++; $display("FAIL bp_count got %0d beats timeout=%0d want 18 0", obs_wa.size(), timed_out);
    end
    vectors++; if (stall_wa.size() != 3) begin miscompares++; $display("FAIL bp_stalls got %0d want 3", stall_wa.size()); end
    for (int i = 0; i < stall_wa.size(); i++) begin
      vectors++;
      if (stall_wa[i] !== 32'd4 || stall_ia[i] !== 32'd11 || stall_vld[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d got wa=%0d ia=%0d valid=%b want 4 11 1", i, stall_wa[i], stall_ia[i], stall_vld[i]);
      end
    end
    for (int i = 0; i < exp_wa.size(); i++) begin
      vectors++;
      if (obs_wa[i] !== exp_wa[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                 i, obs_wa[i], obs_ia[i], obs_last[i], exp_wa[i], exp_ia[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_single();
    cfg_c_fin = 0; cfg_y_fin = 0; cfg_x_fin = 0;
    cfg_w_base = 32'h100; cfg_i_base = 32'h200;
    cfg_w_sc = $urandom; cfg_w_sy = $urandom; cfg_i_sc = $urandom; cfg_i_sy = $urandom;
    kick();
    collect(0, -1, 0, -1, 1'b0);
    vectors++; if (obs_wa.size() != 1) begin miscompares++; $display("FAIL single_count got %0d want 1", obs_wa.size()); end
    vectors++; if (obs_wa[0] !== 32'h100 || obs_ia[0] !== 32'h200 || obs_last[0] !== 1'b1) begin
      miscompares++; $display("FAIL single_beat got wa=%h ia=%h last=%b want 100 200 1", obs_wa[0], obs_ia[0], obs_last[0]);
    end
    vectors++; if (done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
      miscompares++; $display("FAIL single_done got cyc=%0d busy=%b want cyc=%0d busy=0", done_cyc, busy_at_done, last_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0; want[3] = 32'h1;
    cfg_c_fin = 0; cfg_y_fin = 0; cfg_x_fin = 3;
    cfg_w_base = 32'hFFFF_FFFE; cfg_i_base = $urandom;
    cfg_w_sc = $urandom; cfg_w_sy = $urandom; cfg_i_sc = $urandom; cfg_i_sy = $urandom;
    build_model(); kick();
    collect(0, -1, 0, -1, 1'b0);
    vectors++; if (obs_wa.size() != 4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", obs_wa.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_wa[i] !== want[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL wrap_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                 i, obs_wa[i], obs_ia[i], obs_last[i], want[i], exp_ia[i], (i == 3));
      end
    end
  endtask

  task automatic test_start_busy();
    set_basic(); build_model(); kick();
    collect(0, -1, 0, 3, 1'b1);
    vectors++; if (timed_out != 0 || obs_wa.size() != 18) begin
      miscompares++; $display("FAIL busy_start_count got %0d beats timeout=%0d want 18 0", obs_wa.size(), timed_out);
    end
    for (int i = 0; i < exp_wa.size(); i++) begin
      vectors++;
      if (obs_wa[i] !== exp_wa[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL busy_start_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                 i, obs_wa[i], obs_ia[i], obs_last[i], exp_wa[i], exp_ia[i], exp_last[i]);
      end
    end
    collect(0, -1, 0, -1, 1'b0);
    vectors++; if (lat_obs != LAT) begin miscompares++; $display("FAIL done_restart_latency got %0d want %0d", lat_obs, LAT); end
    vectors++; if (obs_wa.size() != 18 || obs_wa[0] !== exp_wa[0] || obs_ia[17] !== exp_ia[17]) begin
      miscompares++; $display("FAIL done_restart_run got %0d beats wa0=%h ia17=%h want 18 %h %h",
                              obs_wa.size(), obs_wa[0], obs_ia[17], exp_wa[0], exp_ia[17]);
    end
  endtask

  task automatic test_reset_midrun();
    int beats, junk;
    bit hit;
    set_basic(); kick();
    beats = 0; hit = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.ready = 1'b1;
      if (bus.valid && beats == 6) begin hit = 1; break; end
      if (bus.valid) beats++;
    end
    vectors++; if (!hit || bus.wa !== 32'd6) begin
      miscompares++; $display("FAIL rstmid_beat7 got reached=%0d wa=%0d want 1 6", hit, bus.wa);
    end
    rst = 1'b1;
    #1;
    vectors++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.last !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_abort got valid=%b busy=%b last=%b want 0 0 0", bus.valid, bus.busy, bus.last);
    end
    @(negedge clk);
    rst = 1'b0;
    junk = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.valid !== 1'b0) junk++;
    end
    vectors++; if (junk != 0) begin miscompares++; $display("FAIL rstmid_nodone got %0d active cycles want 0", junk); end
    cfg_w_base = 32'h40; cfg_i_base = 32'h80;
    build_model(); kick();
    collect(0, -1, 0, -1, 1'b0);
    vectors++; if (obs_wa.size() != 18 || obs_wa[0] !== 32'h40) begin
      miscompares++; $display("FAIL rstmid_fresh got %0d beats wa0=%h want 18 40", obs_wa.size(), obs_wa[0]);
    end
    for (int i = 0; i < exp_wa.size(); i++) begin
      vectors++;
      if (obs_wa[i] !== exp_wa[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                 i, obs_wa[i], obs_ia[i], obs_last[i], exp_wa[i], exp_ia[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 6; run++) begin
      cfg_c_fin = CW'($urandom_range(0, 3)); cfg_y_fin = CW'($urandom_range(0, 3));
      cfg_x_fin = CW'($urandom_range(0, 3));
      cfg_w_base = $urandom; cfg_i_base = $urandom;
      cfg_w_sc = $urandom; cfg_w_sy = $urandom; cfg_i_sc = $urandom; cfg_i_sy = $urandom;
      build_model(); kick();
      collect(2, -1, 0, -1, 1'b0);
      vectors++; if (timed_out != 0 || obs_wa.size() != exp_wa.size()) begin
        miscompares++; $display("FAIL rand%0d_count got %0d timeout=%0d want %0d 0", run, obs_wa.size(), timed_out, exp_wa.size());
      end
      for (int i = 0; i < exp_wa.size(); i++) begin
        vectors++;
        if (obs_wa[i] !== exp_wa[i] || obs_ia[i] !== exp_ia[i] || obs_last[i] !== exp_last[i]) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d got wa=%h ia=%h last=%b want wa=%h ia=%h last=%b",
                   run, i, obs_wa[i], obs_ia[i], obs_last[i], exp_wa[i], exp_ia[i], exp_last[i]);
        end
      end
      vectors++; if (done_cyc != last_cyc + 1 || done_cnt != 1 || busy_low != 0) begin
        miscompares++; $display("FAIL rand%0d_done got cyc=%0d cnt=%0d busylow=%0d want cyc=%0d cnt=1 busylow=0",
                                run, done_cyc, done_cnt, busy_low, last_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_wrap();
    test_start_busy();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loop_addr_gen.md
Name: loop_addr_gen

Overview:
- Runtime-configurable three-level nested loop sequencer: outer loop c, middle loop y, inner loop x.
- Emits one weight address and one input address per iteration over a valid/ready stream.
- Parametrised generalisation of the fixed-bound loop/address generator; feeds the convolution datapath's weight and input buffer read ports.
- Adds per-run bounds, strides, base addresses, back-pressure, busy and done.

Parameters:
- CW, 4, width of each loop index and bound.
- AW, 32, width of addresses, strides and bases.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- c_fin, y_fin, x_fin  in  CW each  inclusive final index per loop.
- w_base, i_base  in  AW each  start addresses.
- w_sc, w_sy  in  AW each  weight address stride per c step and per y step.
- i_sc, i_sy  in  AW each  input address stride per c step and per y step.
- ready  in  1  downstream accepts the current beat.
- valid  out  1  wa/ia/last hold a beat.
- wa, ia  out  AW each  current weight and input addresses.
- last  out  1  current beat is the final iteration.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all indices and accumulators 0; valid, last, busy, done = 0; wa, ia = 0.
- States:
  - IDLE, start=1: latch all configuration inputs; indices := 0; wa := w_base; ia := i_base. Next state RUN.
  - RUN: valid=1 and busy=1. First valid in the cycle after start is sampled (latency 1).
  - Transfer: valid && ready. Without a transfer, wa/ia/last and all indices hold.
  - On a transfer, not last: advance x (x_fin wraps to 0 and carries into y; y_fin wraps to 0 and carries into c).
  - On the transfer of the last beat: go to IDLE; valid=0 and busy=0 next cycle; done=1 for exactly that one cycle.
- Address arithmetic:
  - Incremental only, no multipliers. Each loop keeps a row-start accumulator per address.
  - x step: address +1.
  - y step: address := y-row-start + w_sy (or i_sy).
  - c step: address := c-row-start + w_sc (or i_sc); the y row-start resets to the new c row-start.
  - All sums are modulo 2^AW and wrap silently.
  - Result: wa = w_base + c*w_sc + y*w_sy + x; ia likewise with i_*.
- last = valid && c==c_fin && y==y_fin && x==x_fin.
- Beat count per run = (c_fin+1)(y_fin+1)(x_fin+1). All bounds 0 gives exactly one beat, with last=1.
- start while busy is ignored; configuration changes mid-run have no effect.
- start in the same cycle that done=1 is honoured, since the block is already in IDLE.
- ready is don't-care when valid=0.
- rst asserted mid-run aborts immediately to reset values. No done pulse is generated.

Optional Feature:
- Macro LOOP_ADDR_GEN_REG_OUT_EN.
- Defined: wa/ia/last/valid come from an output register stage.
  - The stage loads when !valid || ready.
  - start-to-first-valid latency is 2 cycles.
  - Full throughput is kept (1 beat/cycle with ready=1).
  - done pulses in the cycle after the last beat leaves the output stage.
  - busy stays high until then.
- Undefined: outputs are driven directly from the counter/accumulator state, with latency 1 as above.

Decomposition:
- Package loop_addr_gen_pkg holds:
  - the state enum (IDLE, RUN);
  - default constants CW_DEF=4 and AW_DEF=32.
- Sub-module loop_lvl, instantiated three times. Each instance is one loop level with:
  - inputs: fin, clear, en (step);
  - outputs: index, at_fin (index==fin), wrap (en && at_fin).
- Top level chains each level's wrap into the next level's en and holds the address accumulators and the FSM.

Test Plan:
- Basic run: c_fin=1, y_fin=2, x_fin=2, w_sc=9, w_sy=3, i_sc=100, i_sy=10, bases 0, ready=1.
  -> 18 consecutive beats; wa = 0..17; ia = 0,1,2,10,11,12,20,21,22,100,...,122.
  -> last only on beat 18 (wa=17, ia=122); done one cycle later.
- Back-pressure: same config, ready=0 for 3 cycles at beat 5.
  -> wa=4, ia=11 held stable with valid=1 throughout.
  -> sequence resumes with no beat lost or duplicated; 18 beats total.
- Single iteration: all fin=0, w_base=0x100, i_base=0x200.
  -> one beat: wa=0x100, ia=0x200, last=1; then done=1, busy=0.
- Wrap: w_base=0xFFFFFFFE, x_fin=3, c_fin=0, y_fin=0.
  -> wa = 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Start while busy: pulse start at beat 4 of the basic run with different bounds.
  -> ignored; run completes unchanged.
  -> start in the done cycle begins a new run the next cycle.
- Reset mid-run: assert rst at beat 7.
  -> valid, busy, last = 0 immediately; no done pulse.
  -> a following start yields a fresh run from wa=w_base.
